mem_access_unit: RTL and testbench

- Load/store initiator that sits between the core's MEM stage and the 8K x 32 word-addressed data memory.
- Accepts byte-addressed LW/LH/LHU/LB/LBU/SW/SH/SB requests over a valid/ready handshake.
- Drives the memory's word address, write data and write enable. Sub-word stores are done as read-modify-write.
- Returns aligned, sign- or zero-extended load data, plus a completion/error pulse, to the pipeline.

---
 rtl/mips_mem_pkg.sv | 24 ++
 rtl/lsu_lane_align.sv | 51 +++++
 rtl/mem_access_unit.sv | 139 +++++++++++++
 tb/tb_mem_access_unit.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_mem_pkg.sv
// Shared types and constants for the data-memory load/store unit.
package mips_mem_pkg;

    // Word-address width of the 8K x 32 data memory.
    localparam int unsigned DMEM_ADDR_W = 13;

    // Access size. The encoding 2'b11 has no enumerator and is decoded as an error.
    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10
    } size_t;

    typedef enum logic [2:0] {
        IDLE,
        LD,
        ST,
        RMW_RD,
        RMW_WR,
        ERR,
        RESP
    } lsu_state_t;

endpackage

// File: rtl/lsu_lane_align.sv
// Little-endian byte-lane steering. Extracts and extends load data from a memory
// word, and merges sub-word store data into a memory word.
module lsu_lane_align
    import mips_mem_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  offset,
    input  size_t       size,
    input  logic        is_unsigned,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] store_word
);

    logic [4:0]  shamt;
    logic [31:0] shifted;
    logic [31:0] lane_mask;

    assign shamt   = {offset, 3'b000};
    assign shifted = word >> shamt;

    // Load path: move the addressed lane to bit 0, then sign- or zero-extend.
    always_comb begin
        load_data = shifted;
        case (size)
            SZ_BYTE: load_data = is_unsigned ? {24'h0, shifted[7:0]}
                                             : {{24{shifted[7]}}, shifted[7:0]};
            SZ_HALF: load_data = is_unsigned ? {16'h0, shifted[15:0]}
                                             : {{16{shifted[15]}}, shifted[15:0]};
            default: load_data = shifted;  // word accesses are aligned, so offset is 0
        endcase
    end

    // Store path: replace only the addressed lane of the old word.
    always_comb begin
        lane_mask  = 32'h0;
        store_word = wdata;
        case (size)
            SZ_BYTE: begin
                lane_mask  = 32'h0000_00ff << shamt;
                store_word = (word & ~lane_mask) | ((wdata & 32'h0000_00ff) << shamt);
            end
            SZ_HALF: begin
                lane_mask  = 32'h0000_ffff << shamt;
                store_word = (word & ~lane_mask) | ((wdata & 32'h0000_ffff) << shamt);
            end
            default: store_word = wdata;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store initiator between the MEM stage and the word-addressed data memory.
// Sub-word stores are performed as a read cycle followed by a merged write cycle.
module mem_access_unit
    import mips_mem_pkg::*;
#(
    parameter int unsigned ADDR_W = DMEM_ADDR_W,
    parameter int unsigned DATA_W = 32
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_req_valid,
    output logic              o_req_ready,
    input  logic              i_req_we,
    input  logic [1:0]        i_req_size,
    input  logic              i_req_unsigned,
    input  logic [31:0]       i_req_addr,
    input  logic [DATA_W-1:0] i_req_wdata,
    output logic              o_rsp_valid,
    output logic [DATA_W-1:0] o_rsp_rdata,
    output logic              o_rsp_err,
    output logic [ADDR_W-1:0] o_mem_A,
    output logic [DATA_W-1:0] o_mem_WD,
    output logic              o_mem_WE,
    input  logic [DATA_W-1:0] i_mem_RD
);

    lsu_state_t        state_q, state_d;
    logic              accept;
    logic              req_err;
    logic [ADDR_W-1:0] addr_q;
    logic [1:0]        off_q;
    logic [1:0]        size_q;
    logic              uns_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] mem_wd_q;
    logic [DATA_W-1:0] rsp_rdata_q;
    logic              rsp_err_q;
    logic [31:0]       load_data;
    logic [31:0]       store_word;

    assign accept = i_req_valid & o_req_ready;

    // Request legality: size, alignment and range are all judged at accept.
    always_comb begin
        req_err = 1'b0;
        if (i_req_size == 2'b11) req_err = 1'b1;
        if (i_req_size == SZ_HALF && i_req_addr[0]) req_err = 1'b1;
        if (i_req_size == SZ_WORD && i_req_addr[1:0] != 2'b00) req_err = 1'b1;
        if (|i_req_addr[31:ADDR_W+2]) req_err = 1'b1;
    end

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_rst) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (req_err)                   state_d = ERR;
                    else if (!i_req_we)            state_d = LD;
                    else if (i_req_size == SZ_WORD) state_d = ST;
                    else                           state_d = RMW_RD;
                end
            end
            LD, ST, ERR: state_d = RESP;
            RMW_RD:      state_d = RMW_WR;
            RMW_WR:      state_d = RESP;
            RESP:        state_d = IDLE;
            default:     state_d = IDLE;
        endcase
    end

    // FSM outputs; reset gates the handshake and write strobe immediately.
    always_comb begin
        o_req_ready = (state_q == IDLE) & ~i_rst;
        o_mem_WE    = ((state_q == ST) | (state_q == RMW_WR)) & ~i_rst;
        o_rsp_valid = (state_q == RESP);
    end

    // Request capture, store-word staging and response registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            addr_q      <= '0;
            off_q       <= '0;
            size_q      <= '0;
            uns_q       <= 1'b0;
            wdata_q     <= '0;
            mem_wd_q    <= '0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            if (accept) begin
                addr_q  <= i_req_addr[ADDR_W+1:2];
                off_q   <= i_req_addr[1:0];
                size_q  <= i_req_size;
                uns_q   <= i_req_unsigned;
                wdata_q <= i_req_wdata;
                if (state_d == ST) mem_wd_q <= i_req_wdata;
            end
            case (state_q)
                LD: begin
                    rsp_rdata_q <= load_data;
                    rsp_err_q   <= 1'b0;
                end
                RMW_RD: mem_wd_q <= store_word;
                ERR: begin
                    rsp_rdata_q <= '0;
                    rsp_err_q   <= 1'b1;
                end
                ST, RMW_WR: begin
                    rsp_rdata_q <= '0;
                    rsp_err_q   <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    lsu_lane_align u_lane_align (
        .word        (i_mem_RD),
        .offset      (off_q),
        .size        (size_t'(size_q)),
        .is_unsigned (uns_q),
        .wdata       (wdata_q),
        .load_data   (load_data),
        .store_word  (store_word)
    );

    assign o_mem_A     = addr_q;
    assign o_mem_WD    = mem_wd_q;
    assign o_rsp_rdata = rsp_rdata_q;
    assign o_rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit with a behavioural 8K x 32 data memory.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [12:0] mem_a;
    logic [31:0] mem_wd;
    logic        mem_we;
    logic [31:0] mem_rd;

    logic [31:0] mem [0:8191];

    int total = 0;
    int bad = 0;
    int cyc = 0;

    typedef struct {
        string       name;
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          we_off;
        logic [12:0] we_addr;
        int          acc;
    } exp_t;

    exp_t pend_q[$];
    exp_t sb_q[$];
    int   acc_log[$];
    int   cur_we_cyc = -1;
    logic [12:0] cur_we_addr = '0;
    logic we_seen = 1'b0;

    mem_access_unit #(
        .ADDR_W (13),
        .DATA_W (32)
    ) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_req_valid    (req_valid),
        .o_req_ready    (req_ready),
        .i_req_we       (req_we),
        .i_req_size     (req_size),
        .i_req_unsigned (req_unsigned),
        .i_req_addr     (req_addr),
        .i_req_wdata    (req_wdata),
        .o_rsp_valid    (rsp_valid),
        .o_rsp_rdata    (rsp_rdata),
        .o_rsp_err      (rsp_err),
        .o_mem_A        (mem_a),
        .o_mem_WD       (mem_wd),
        .o_mem_WE       (mem_we),
        .i_mem_RD       (mem_rd)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    assign mem_rd = mem[mem_a];
    always @(posedge clk) if (mem_we) mem[mem_a] <= mem_wd;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail(input string name);
        total++;
        bad++;
        $display("FAIL %s: event missing or unexpected (cycle %0d)", name, cyc);
    endtask

    // Monitors: accept capture, write-strobe checking, response scoreboard.
    always @(negedge clk) begin
        exp_t e;
        if (req_valid && req_ready) begin
            if (pend_q.size() == 0) begin
                fail("unexpected_accept");
            end else begin
                e = pend_q.pop_front();
                e.acc = cyc;
                sb_q.push_back(e);
                cur_we_cyc  = (e.we_off != 0) ? cyc + e.we_off : -1;
                cur_we_addr = e.we_addr;
                we_seen     = 1'b0;
                acc_log.push_back(cyc);
            end
        end
        if (mem_we) begin
            check("we_cycle", 32'(cyc), 32'(cur_we_cyc));
            check("we_addr", {19'h0, mem_a}, {19'h0, cur_we_addr});
            we_seen = 1'b1;
        end
        if (rsp_valid) begin
            if (sb_q.size() == 0) begin
                fail("unexpected_rsp");
            end else begin
                e = sb_q.pop_front();
                check({e.name, "_rdata"}, rsp_rdata, e.rdata);
                check({e.name, "_err"}, {31'h0, rsp_err}, {31'h0, e.err});
                check({e.name, "_lat"}, 32'(cyc - e.acc), 32'(e.lat));
                if (e.we_off != 0) check({e.name, "_we_seen"}, {31'h0, we_seen}, 32'h1);
            end
        end
    end

    task automatic drain(input string name);
        int k = 0;
        while (sb_q.size() != 0 && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (sb_q.size() != 0) begin
            fail({name, "_rsp_timeout"});
            sb_q.delete();
        end
    endtask

    task automatic drive(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata);
        req_we       = we;
        req_size     = size;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wdata;
        req_valid    = 1'b1;
    endtask

    function automatic exp_t mk(input string name, input logic [31:0] rdata, input logic err,
                                input int lat, input int we_off, input logic [31:0] addr);
        exp_t e;
        e.name = name; e.rdata = rdata; e.err = err; e.lat = lat;
        e.we_off = we_off; e.we_addr = addr[14:2]; e.acc = 0;
        return e;
    endfunction

    task automatic issue(input string name, input logic we, input logic [1:0] size,
                         input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] rdata, input logic err, input int lat,
                         input int we_off);
        int   k = 0;
        logic got = 1'b0;
        pend_q.push_back(mk(name, rdata, err, lat, we_off, addr));
        @(posedge clk); #1;
        drive(we, size, uns, addr, wdata);
        while (!got && k < 20) begin
            @(negedge clk);
            got = req_ready;
            k++;
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        if (!got) begin
            fail({name, "_accept_timeout"});
            pend_q.delete();
        end
        drain(name);
    endtask

    // Holds valid high for three requests and checks the accept spacing.
    task automatic b2b(input string name, input logic we, input logic [1:0] size,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] rdata, input int lat, input int we_off,
                       input int gap);
        int k = 0;
        for (int i = 0; i < 3; i++) pend_q.push_back(mk(name, rdata, 1'b0, lat, we_off, addr));
        acc_log.delete();
        @(posedge clk); #1;
        drive(we, size, 1'b0, addr, wdata);
        while (acc_log.size() < 3 && k < 40) begin
            @(negedge clk);
            k++;
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        if (acc_log.size() < 3) begin
            fail({name, "_accept_timeout"});
            pend_q.delete();
        end else begin
            check({name, "_gap0"}, 32'(acc_log[1] - acc_log[0]), 32'(gap));
            check({name, "_gap1"}, 32'(acc_log[2] - acc_log[1]), 32'(gap));
        end
        drain(name);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        mem[4] <= 32'h1122_3344;
        mem[5] <= 32'h8000_ff80;

        // Reset values.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ready", {31'h0, req_ready}, 32'h0);
        check("rst_we", {31'h0, mem_we}, 32'h0);
        check("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
        check("rst_rdata", rsp_rdata, 32'h0);
        check("rst_err", {31'h0, rsp_err}, 32'h0);
        check("rst_mem_a", {19'h0, mem_a}, 32'h0);
        check("rst_mem_wd", mem_wd, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Loads: name, we, size, uns, addr, wdata, rdata, err, lat, we_off
        issue("lb_13",  1'b0, 2'b00, 1'b0, 32'h13, 32'h0, 32'h0000_0011, 1'b0, 2, 0);
        issue("lhu_10", 1'b0, 2'b01, 1'b1, 32'h10, 32'h0, 32'h0000_3344, 1'b0, 2, 0);
        issue("lw_10",  1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'h1122_3344, 1'b0, 2, 0);
        issue("lb_14",  1'b0, 2'b00, 1'b0, 32'h14, 32'h0, 32'hffff_ff80, 1'b0, 2, 0);
        issue("lbu_14", 1'b0, 2'b00, 1'b1, 32'h14, 32'h0, 32'h0000_0080, 1'b0, 2, 0);
        issue("lh_16",  1'b0, 2'b01, 1'b0, 32'h16, 32'h0, 32'hffff_8000, 1'b0, 2, 0);

        // Sub-word stores (read-modify-write) and a word store.
        issue("sb_11", 1'b1, 2'b00, 1'b0, 32'h11, 32'hffff_ffab, 32'h0, 1'b0, 3, 2);
        check("mem4_after_sb", mem[4], 32'h1122_ab44);
        issue("sh_12", 1'b1, 2'b01, 1'b0, 32'h12, 32'h0000_beef, 32'h0, 1'b0, 3, 2);
        check("mem4_after_sh", mem[4], 32'hbeef_ab44);
        issue("sw_20", 1'b1, 2'b10, 1'b0, 32'h20, 32'hdead_beef, 32'h0, 1'b0, 2, 1);
        check("mem8_after_sw", mem[8], 32'hdead_beef);
        issue("lw_20", 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 32'hdead_beef, 1'b0, 2, 0);

        // Error cases: no write, err response at N+2.
        issue("err_lw_12",   1'b0, 2'b10, 1'b0, 32'h12,   32'h0, 32'h0, 1'b1, 2, 0);
        issue("err_sh_11",   1'b1, 2'b01, 1'b0, 32'h11,   32'h1234, 32'h0, 1'b1, 2, 0);
        issue("err_lw_8000", 1'b0, 2'b10, 1'b0, 32'h8000, 32'h0, 32'h0, 1'b1, 2, 0);
        issue("err_size11",  1'b0, 2'b11, 1'b0, 32'h10,   32'h0, 32'h0, 1'b1, 2, 0);
        check("mem4_after_err", mem[4], 32'hbeef_ab44);

        // Reset while the read half of SB 0x10 is in flight.
        pend_q.push_back(mk("sb_rst", 32'h0, 1'b0, 3, 2, 32'h10));
        @(posedge clk); #1;
        drive(1'b1, 2'b00, 1'b0, 32'h10, 32'h0000_0055);
        @(negedge clk);
        check("sb_rst_ready", {31'h0, req_ready}, 32'h1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_we", {31'h0, mem_we}, 32'h0);
        check("rst_mid_ready", {31'h0, req_ready}, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        sb_q.delete();
        cur_we_cyc = -1;
        @(negedge clk);
        check("post_rst_ready", {31'h0, req_ready}, 32'h1);
        repeat (6) @(negedge clk);
        check("mem4_after_rst", mem[4], 32'hbeef_ab44);

        // Back-to-back requests with valid held high.
        b2b("b2b_lw", 1'b0, 2'b10, 32'h10, 32'h0, 32'hbeef_ab44, 2, 0, 3);
        b2b("b2b_sb", 1'b1, 2'b00, 32'h13, 32'h0000_0012, 32'h0, 3, 2, 4);
        check("mem4_after_b2b", mem[4], 32'h12ef_ab44);

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
